uni_shift_reg: RTL and testbench
================================

Name: uni_shift_reg

Overview:
- Parametrised successor of the 8-bit enable register: a WIDTH-bit register with hold, parallel load, shift, rotate and arithmetic-shift modes.
- Adds a serial-load state machine that assembles a word from a 1-bit input over WIDTH cycles and reports completion.
- Sits between the combinational datapath and the serial I/O blocks; it is the general-purpose storage element for new designs.

Parameters:
WIDTH, 8, register width in bits; legal range is WIDTH >= 2.
RESET_VAL, 0, value loaded into Reg_Out by reset.

Ports:
clk  input  1  clock; all state updates on the rising edge.
res  input  1  synchronous, active-low reset.
EN  input  1  clock enable; when low, all state holds, including the FSM and the counter.
mode  input  3  operation select; encodings are in the package.
Reg_In  input  WIDTH  parallel load data.
ser_in  input  1  serial data for shift/serial-load fill.
Reg_Out  output  WIDTH  registered contents.
ser_out  output  1  registered bit most recently shifted out.
busy  output  1  high while a serial load is in progress.
done  output  1  one-cycle pulse when a serial load completes.

Behaviour:
- Reset:
  - res sampled low at a clk edge sets Reg_Out=RESET_VAL, ser_out=0, busy=0, done=0, state=IDLE and count=0.
  - Reset has priority over EN.
- EN=0: no state changes. done is registered, so a pending done pulse still drops after one cycle.
- IDLE with EN=1, mode decode (1-cycle latency, result visible after the edge):
  - HOLD(000): no change.
  - LOAD(001): Reg_Out<=Reg_In.
  - SHL(010): Reg_Out<={Reg_Out[W-2:0],ser_in}; ser_out<=Reg_Out[W-1].
  - SHR(011): Reg_Out<={ser_in,Reg_Out[W-1:1]}; ser_out<=Reg_Out[0].
  - ROL(100): rotate left by 1; ser_out<=Reg_Out[W-1].
  - ROR(101): rotate right by 1; ser_out<=Reg_Out[0].
  - ASR(110): Reg_Out<={Reg_Out[W-1],Reg_Out[W-1:1]}; ser_out<=Reg_Out[0].
  - SLOAD(111): state<=SHIFT, busy<=1, count<=0; Reg_Out is unchanged on this cycle.
- SHIFT state, on each edge with EN=1:
  - Capture Reg_Out<={Reg_Out[W-2:0],ser_in}, so data enters MSB-first, and ser_out<=Reg_Out[W-1].
  - count<=count+1.
  - When count==WIDTH-1 at capture: state<=IDLE, busy<=0, done<=1 for exactly the next cycle.
- Counter width is $clog2(WIDTH) bits, with no wrap beyond WIDTH-1.
- mode is ignored while busy=1. A new op is accepted on the first cycle busy=0, including a back-to-back SLOAD in the cycle done is high.
- EN=0 during SHIFT freezes count and Reg_Out; capture resumes when EN returns.
- Reset during SHIFT aborts immediately: busy=0, done=0, and a partial word is discarded (Reg_Out=RESET_VAL).
- done is otherwise 0.

Optional Feature:
- Macro: UNI_SHIFT_REG_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit), registered, equal to the XOR of the next Reg_Out value, updated on the same edge as Reg_Out.
  - Reset value equals the XOR of RESET_VAL.
  - Holds when EN=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package uni_shift_reg_pkg:
  - mode localparams MODE_HOLD..MODE_SLOAD (3-bit).
  - FSM state encodings ST_IDLE, ST_SHIFT.
- Sub-module shift_next (combinational): takes mode, Reg_Out, ser_in and returns the next value and shift-out bit. The top module holds the registers, FSM and counter.

Test Plan:
1. WIDTH=8. Reset, then LOAD Reg_In=8'hA5 -> Reg_Out=8'hA5 one cycle later. HOLD for 3 cycles -> stays 8'hA5.
2. Reg_Out=8'h81:
   - SHL with ser_in=0 -> 8'h02, ser_out=1.
   - ROR -> 8'h01, ser_out=0.
   - Load 8'h80, then ASR -> 8'hC0, ser_out=0.
3. SLOAD, then ser_in=1,0,1,1,0,0,1,0 over 8 cycles:
   - busy is high for 8 cycles.
   - Reg_Out=8'hB2.
   - done pulses once on the cycle after the last capture.
   - mode=LOAD driven mid-load is ignored.
4. SLOAD with EN=0 for 2 cycles after bit 3 -> count and Reg_Out frozen; the final word is still correct and done is delayed by 2 cycles.
5. res=0 after bit 5 of a serial load -> next cycle Reg_Out=0, busy=0, done never pulses. EN=0 with res=0 still resets.
6. With UNI_SHIFT_REG_PARITY_EN defined:
   - LOAD 8'h07 -> parity=1.
   - SHL with ser_in=1 -> 8'h0F, parity=0.

Source files
------------

// File: rtl/uni_shift_reg_pkg.sv
// rtl/uni_shift_reg_pkg.sv - mode and FSM encodings shared by uni_shift_reg and shift_next
package uni_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'b000;
  localparam logic [2:0] MODE_LOAD  = 3'b001;
  localparam logic [2:0] MODE_SHL   = 3'b010;
  localparam logic [2:0] MODE_SHR   = 3'b011;
  localparam logic [2:0] MODE_ROL   = 3'b100;
  localparam logic [2:0] MODE_ROR   = 3'b101;
  localparam logic [2:0] MODE_ASR   = 3'b110;
  localparam logic [2:0] MODE_SLOAD = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/uni_shift_reg_shift_next.sv
// rtl/uni_shift_reg_shift_next.sv - combinational next value and shift-out bit for shift/rotate modes
module shift_next #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] cur_i,
  input  logic             ser_in_i,
  output logic [WIDTH-1:0] nxt_o,
  output logic             sout_o,
  output logic             shift_o
);
  import uni_shift_reg_pkg::*;

  // shift_o marks modes that move bits and therefore update ser_out
  always_comb begin
    nxt_o   = cur_i;
    sout_o  = 1'b0;
    shift_o = 1'b0;
    case (mode_i)
      MODE_SHL: begin
        nxt_o   = {cur_i[WIDTH-2:0], ser_in_i};
        sout_o  = cur_i[WIDTH-1];
        shift_o = 1'b1;
      end
      MODE_SHR: begin
        nxt_o   = {ser_in_i, cur_i[WIDTH-1:1]};
        sout_o  = cur_i[0];
        shift_o = 1'b1;
      end
      MODE_ROL: begin
        nxt_o   = {cur_i[WIDTH-2:0], cur_i[WIDTH-1]};
        sout_o  = cur_i[WIDTH-1];
        shift_o = 1'b1;
      end
      MODE_ROR: begin
        nxt_o   = {cur_i[0], cur_i[WIDTH-1:1]};
        sout_o  = cur_i[0];
        shift_o = 1'b1;
      end
      MODE_ASR: begin
        nxt_o   = {cur_i[WIDTH-1], cur_i[WIDTH-1:1]};
        sout_o  = cur_i[0];
        shift_o = 1'b1;
      end
      default: begin
        nxt_o   = cur_i;
        sout_o  = 1'b0;
        shift_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/uni_shift_reg.sv
// rtl/uni_shift_reg.sv - universal shift register with serial-load FSM; UNI_SHIFT_REG_PARITY_EN adds parity output
module uni_shift_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res,
  input  logic             EN,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] Reg_In,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Reg_Out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
`ifdef UNI_SHIFT_REG_PARITY_EN
  ,
  output logic             parity
`endif
);
  import uni_shift_reg_pkg::*;

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] reg_q, reg_d;
  logic             ser_q, ser_d;
  logic             done_q, done_d;

  logic [2:0]       eff_mode;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_out;
  logic             sh_valid;

  // Serial capture reuses the SHL path so data enters MSB-first
  assign eff_mode = (state_q == ST_SHIFT) ? MODE_SHL : mode;

  shift_next #(.WIDTH(WIDTH)) u_shift_next (
    .mode_i   (eff_mode),
    .cur_i    (reg_q),
    .ser_in_i (ser_in),
    .nxt_o    (sh_nxt),
    .sout_o   (sh_out),
    .shift_o  (sh_valid)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    reg_d   = reg_q;
    ser_d   = ser_q;
    done_d  = 1'b0;
    if (EN) begin
      if (state_q == ST_SHIFT) begin
        reg_d = sh_nxt;
        ser_d = sh_out;
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = ST_IDLE;
          count_d = '0;
          done_d  = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else if (mode == MODE_SLOAD) begin
        state_d = ST_SHIFT;
        count_d = '0;
      end else if (mode == MODE_LOAD) begin
        reg_d = Reg_In;
      end else if (sh_valid) begin
        reg_d = sh_nxt;
        ser_d = sh_out;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      reg_q   <= RESET_VAL;
      ser_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      reg_q   <= reg_d;
      ser_q   <= ser_d;
      done_q  <= done_d;
    end
  end

`ifdef UNI_SHIFT_REG_PARITY_EN
  logic parity_q;

  // reg_d equals reg_q when EN is low, so parity holds without a separate enable
  always_ff @(posedge clk) begin
    if (!res) begin
      parity_q <= ^RESET_VAL;
    end else begin
      parity_q <= ^reg_d;
    end
  end

  assign parity = parity_q;
`endif

  assign Reg_Out = reg_q;
  assign ser_out = ser_q;
  assign busy    = (state_q == ST_SHIFT);
  assign done    = done_q;

endmodule

// File: tb/tb_uni_shift_reg.sv
// tb/tb_uni_shift_reg.sv - scoreboard bench for uni_shift_reg (WIDTH=8)
module tb_uni_shift_reg;
  import uni_shift_reg_pkg::*;

  logic       clk = 1'b0;
  logic       res, EN, ser_in;
  logic [2:0] mode;
  logic [7:0] Reg_In, Reg_Out;
  logic       ser_out, busy, done;
`ifdef UNI_SHIFT_REG_PARITY_EN
  logic       parity;
`endif

  uni_shift_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk     (clk),
    .res     (res),
    .EN      (EN),
    .mode    (mode),
    .Reg_In  (Reg_In),
    .ser_in  (ser_in),
    .Reg_Out (Reg_Out),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
`ifdef UNI_SHIFT_REG_PARITY_EN
    ,
    .parity  (parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      nm;
    logic [7:0] r;
    logic       cs;
    logic       so;
    logic       b;
    logic       d;
  } exp_t;

  exp_t sb[$];
  int   cyc_cnt = 0;
  int   n_chk   = 0;
  int   n_fail  = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // Monitor: compares every expectation due for the cycle just clocked
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
      exp_t e;
      logic ok;
      e  = sb.pop_front();
      ok = (Reg_Out === e.r) && (!e.cs || ser_out === e.so) &&
           (busy === e.b) && (done === e.d) && (e.cyc == cyc_cnt);
`ifdef UNI_SHIFT_REG_PARITY_EN
      ok = ok && (parity === ^e.r);
`endif
      n_chk++;
      if (!ok) begin
        n_fail++;
        $display("FAIL %s: got reg=%h ser=%b busy=%b done=%b, want reg=%h ser=%b(chk=%b) busy=%b done=%b",
                 e.nm, Reg_Out, ser_out, busy, done, e.r, e.so, e.cs, e.b, e.d);
      end
    end
  end

  task automatic drive(input logic r, input logic e, input logic [2:0] m,
                       input logic [7:0] d, input logic s);
    res = r; EN = e; mode = m; Reg_In = d; ser_in = s;
  endtask

  task automatic expect_next(input string nm, input logic [7:0] r, input logic cs,
                             input logic so, input logic b, input logic d);
    exp_t e;
    e.cyc = cyc_cnt + 1; e.nm = nm; e.r = r; e.cs = cs; e.so = so; e.b = b; e.d = d;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  logic       bits  [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  // Serial load starting from 8'hC0
  logic [7:0] r3    [8] = '{8'h81, 8'h02, 8'h05, 8'h0B, 8'h16, 8'h2C, 8'h59, 8'hB2};
  logic       s3    [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Serial load starting from 8'hB2
  logic [7:0] r4    [8] = '{8'h65, 8'hCA, 8'h95, 8'h2B, 8'h56, 8'hAC, 8'h59, 8'hB2};
  logic       s4    [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

  initial begin
    drive(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    tick();

    expect_next("reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    drive(1'b1, 1'b1, MODE_LOAD, 8'hA5, 1'b0);
    expect_next("load_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_HOLD, 8'h3C, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_next($sformatf("hold_%0d", i), 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end

    drive(1'b1, 1'b1, MODE_LOAD, 8'h81, 1'b0);
    expect_next("load_81", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b0);
    expect_next("shl", 8'h02, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_ROR, 8'h00, 1'b1);
    expect_next("ror", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_LOAD, 8'h80, 1'b0);
    expect_next("load_80", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_ASR, 8'h00, 1'b0);
    expect_next("asr", 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_ROL, 8'h00, 1'b0);
    expect_next("rol", 8'h81, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_SHR, 8'h00, 1'b1);
    expect_next("shr", 8'hC0, 1'b1, 1'b1, 1'b0, 1'b0); tick();

    // Serial load; LOAD driven on every capture cycle must be ignored
    drive(1'b1, 1'b1, MODE_SLOAD, 8'hFF, 1'b0);
    expect_next("sload3_start", 8'hC0, 1'b1, 1'b1, 1'b1, 1'b0); tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, MODE_LOAD, 8'hFF, bits[i]);
      expect_next($sformatf("sload3_bit%0d", i), r3[i], 1'b1, s3[i], i != 7, i == 7); tick();
    end
    drive(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    expect_next("sload3_after", 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    // Serial load with a 2-cycle EN gap after bit 3
    drive(1'b1, 1'b1, MODE_SLOAD, 8'h00, 1'b0);
    expect_next("sload4_start", 8'hB2, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        drive(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b1);
        expect_next("sload4_gap0", 8'h95, 1'b1, 1'b1, 1'b1, 1'b0); tick();
        expect_next("sload4_gap1", 8'h95, 1'b1, 1'b1, 1'b1, 1'b0); tick();
      end
      drive(1'b1, 1'b1, MODE_HOLD, 8'h00, bits[i]);
      expect_next($sformatf("sload4_bit%0d", i), r4[i], 1'b1, s4[i], i != 7, i == 7); tick();
    end
    drive(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    expect_next("sload4_after", 8'hB2, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    // Reset aborts a serial load after bit 5
    drive(1'b1, 1'b1, MODE_SLOAD, 8'h00, 1'b0);
    expect_next("sload5_start", 8'hB2, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, MODE_HOLD, 8'h00, bits[i]);
      expect_next($sformatf("sload5_bit%0d", i), r4[i], 1'b1, s4[i], 1'b1, 1'b0); tick();
    end
    drive(1'b0, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    expect_next("abort_reset", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_next($sformatf("abort_nodone%0d", i), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    end

    // Reset wins over EN=0; EN=0 otherwise holds
    drive(1'b1, 1'b1, MODE_LOAD, 8'h5A, 1'b0);
    expect_next("load_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b0, MODE_LOAD, 8'hFF, 1'b0);
    expect_next("en0_hold", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, 1'b0, MODE_LOAD, 8'hFF, 1'b0);
    expect_next("reset_en0", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    // Parity: 07 -> 1, then SHL with 1 -> 0F -> 0
    drive(1'b1, 1'b1, MODE_LOAD, 8'h07, 1'b0);
    expect_next("par_load_07", 8'h07, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 1'b1, MODE_SHL, 8'h00, 1'b1);
    expect_next("par_shl", 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0); tick();

    drive(1'b1, 1'b1, MODE_HOLD, 8'h00, 1'b0);
    tick(); tick();
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
